// File: rtl/fetch_pkg.sv
// Shared defaults and FSM encodings for the instruction prefetch stage.
package fetch_pkg;

  localparam int PC_W_DEF     = 8;
  localparam int INSTR_W_DEF  = 16;
  localparam int RESET_PC_DEF = 0;

  localparam logic [1:0] ST_START  = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_SQUASH = 2'd2;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is read straight from storage at the
// registered read pointer so it never depends on this cycle's pop.
module fetch_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 24
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_clear,
  input  logic [DATA_W-1:0]      i_data,
  output logic [DATA_W-1:0]      o_head,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_pop;

  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && !i_clear && r_count == (AW+1)'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction prefetch: issues sequential reads under a credit limit, tags
// returning words with their PC, and flushes everything on a redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PC_W     = PC_W_DEF,
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [PC_W-1:0]        imem_addr,
  output logic                   imem_en,
  input  logic [INSTR_W-1:0]     imem_data,
  input  logic                   redirect,
  input  logic [PC_W-1:0]        redirect_pc,
  output logic [INSTR_W-1:0]     instr,
  output logic [PC_W-1:0]        instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [PC_W-1:0]        fetch_pc,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [PC_W-1:0] LP_RESET_PC = PC_W'(RESET_PC);

  logic [1:0]              r_state;
  logic [PC_W-1:0]         r_fetch_pc;
  logic [PC_W-1:0]         r_inflight_pc;
  logic                    r_inflight_vld;
  logic                    w_issue;
  logic                    w_push;
  logic                    w_pop;
  logic [CNT_W-1:0]        w_credit;
  logic [INSTR_W+PC_W-1:0] w_head;

  // Credit counts the outstanding read but not a same-cycle pop, so a full
  // FIFO always has room for the word already in flight.
  assign w_credit = occupancy + CNT_W'(r_inflight_vld);
  assign w_issue  = !reset && !redirect
                  && (r_state == ST_RUN || r_state == ST_SQUASH)
                  && (w_credit < CNT_W'(DEPTH));
  assign w_push   = r_inflight_vld && !redirect && !reset;
  assign w_pop    = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_START;
      r_fetch_pc     <= LP_RESET_PC;
      r_inflight_vld <= 1'b0;
    end else begin
      if (redirect)                r_state <= ST_SQUASH;
      else if (r_state != ST_RUN)  r_state <= ST_RUN;

      if (redirect)     r_fetch_pc <= redirect_pc;
      else if (w_issue) r_fetch_pc <= r_fetch_pc + 1'b1;

      r_inflight_vld <= w_issue;
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) r_inflight_pc <= r_fetch_pc;
  end

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (INSTR_W + PC_W)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (redirect),
    .i_data  ({imem_data, r_inflight_pc}),
    .o_head  (w_head),
    .o_valid (instr_valid),
    .o_count (occupancy)
  );

  assign imem_en   = w_issue;
  assign imem_addr = r_fetch_pc;
  assign fetch_pc  = r_fetch_pc;
  assign instr     = w_head[INSTR_W+PC_W-1:PC_W];
  assign instr_pc  = w_head[PC_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a PC scoreboard checks every accepted
// instruction, plus timing checks around reset, back-pressure and redirects.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, redirect, instr_ready;
  logic [7:0] redirect_pc;
  logic [7:0] imem_addr, instr_pc, fetch_pc;
  logic       imem_en, instr_valid;
  logic [15:0] imem_data, instr;
  logic [2:0] occupancy;

  logic       fe_redirect = 1'b0;
  logic       fe_ready    = 1'b1;
  logic [7:0] fe_rpc      = 8'h00;
  logic [7:0] fe_imem_addr, fe_instr_pc, fe_fetch_pc;
  logic       fe_imem_en, fe_instr_valid;
  logic [15:0] fe_imem_data, fe_instr;
  logic [2:0] fe_occupancy;

  fetch_unit #(.DEPTH(4), .PC_W(8), .INSTR_W(16), .RESET_PC(0)) u_dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_en(imem_en),
    .imem_data(imem_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .fetch_pc(fetch_pc), .occupancy(occupancy)
  );

  fetch_unit #(.DEPTH(4), .PC_W(8), .INSTR_W(16), .RESET_PC(8'hFE)) u_fe (
    .clk(clk), .reset(reset), .imem_addr(fe_imem_addr), .imem_en(fe_imem_en),
    .imem_data(fe_imem_data), .redirect(fe_redirect), .redirect_pc(fe_rpc),
    .instr(fe_instr), .instr_pc(fe_instr_pc), .instr_valid(fe_instr_valid),
    .instr_ready(fe_ready), .fetch_pc(fe_fetch_pc), .occupancy(fe_occupancy)
  );

  // Synchronous-read memory: word k holds 16'h1000 + k.
  always @(posedge clk) if (imem_en)    imem_data    <= 16'h1000 + {8'h00, imem_addr};
  always @(posedge clk) if (fe_imem_en) fe_imem_data <= 16'h1000 + {8'h00, fe_imem_addr};

  int         n_cmp = 0;
  int         n_err = 0;
  logic       sb_en = 1'b0;
  logic [7:0] sb_q[$];
  logic [7:0] fe_exp [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic rd, input logic rr, input logic [7:0] rp);
    logic [7:0] exp_pc;
    @(posedge clk);
    #1;
    reset = r; instr_ready = rd; redirect = rr; redirect_pc = rp;
    #1;
    if (sb_en && instr_valid && instr_ready) begin
      n_cmp++;
      assert (sb_q.size() > 0) else begin
        n_err++;
        $error("FAIL sb_extra: observed pc 0x%0h expected no delivery", instr_pc);
      end
      if (sb_q.size() > 0) begin
        exp_pc = sb_q.pop_front();
        chk("sb_pc", {24'd0, instr_pc}, {24'd0, exp_pc});
        chk("sb_instr", {16'd0, instr}, 32'h1000 + {24'd0, exp_pc});
      end
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic drain(input string tag, input int budget);
    int b = budget;
    while (sb_q.size() > 0 && b > 0) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      b--;
    end
    sb_en = 1'b0;
    chk(tag, sb_q.size(), 0);
  endtask

  task automatic stream_check(input int n);
    sb_q.delete();
    for (int i = 0; i < n; i++) sb_q.push_back(8'(i));
    sb_en = 1'b1;
    for (int k = 0; k < n + 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      if (k < 3) chk("lat_valid_low", instr_valid, 0);
      else       chk("stream_valid", instr_valid, 1);
      if (k == 0) begin
        chk("start_occ", occupancy, 0);
        chk("start_fetch_pc", fetch_pc, 0);
        chk("start_no_issue", imem_en, 0);
      end
      if (k == 1) begin
        chk("first_issue_en", imem_en, 1);
        chk("first_issue_addr", imem_addr, 0);
      end
      if (k == 2) chk("empty_pop_occ", occupancy, 0);
      if (k >= 3 && k <= 6) begin
        chk("fe_valid", fe_instr_valid, 1);
        chk("fe_wrap_pc", fe_instr_pc, fe_exp[k-3]);
      end
    end
    sb_en = 1'b0;
    chk("stream_drained", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    fe_exp[0] = 8'hFE; fe_exp[1] = 8'hFF; fe_exp[2] = 8'h00; fe_exp[3] = 8'h01;
    reset = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;

    // Reset state, then free-running stream from RESET_PC.
    do_reset();
    chk("rst_occ", occupancy, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_en", imem_en, 0);
    chk("rst_fetch_pc", fetch_pc, 0);
    chk("rst_fe_fetch_pc", fe_fetch_pc, 8'hFE);
    stream_check(12);

    // Back-pressure: FIFO fills to DEPTH, issue stops, then drains in order.
    do_reset();
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("bp_occ_full", occupancy, 4);
    chk("bp_en_off", imem_en, 0);
    chk("bp_fetch_pc", fetch_pc, 4);
    chk("bp_valid", instr_valid, 1);
    sb_q.delete();
    for (int i = 0; i < 8; i++) sb_q.push_back(8'(i));
    sb_en = 1'b1;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("bp_no_issue_on_release", imem_en, 0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("bp_resume_en", imem_en, 1);
    chk("bp_resume_addr", imem_addr, 4);
    drain("bp_drain", 20);

    // Redirect with 3 buffered entries and one read in flight.
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h40);
    chk("rd_occ_before", occupancy, 3);
    chk("rd_no_issue", imem_en, 0);
    sb_q.delete();
    for (int i = 0; i < 4; i++) sb_q.push_back(8'h40 + 8'(i));
    sb_en = 1'b1;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("rd_t1_en", imem_en, 1);
    chk("rd_t1_addr", imem_addr, 8'h40);
    chk("rd_t1_occ", occupancy, 0);
    chk("rd_t1_valid", instr_valid, 0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("rd_t2_valid", instr_valid, 0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("rd_t3_valid", instr_valid, 1);
    chk("rd_t3_pc", instr_pc, 8'h40);
    drain("rd_drain", 10);

    // Back-to-back redirects: only the second target survives.
    do_reset();
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h10);
    sb_q.delete();
    for (int i = 0; i < 4; i++) sb_q.push_back(8'h20 + 8'(i));
    sb_en = 1'b1;
    step(1'b0, 1'b1, 1'b1, 8'h20);
    chk("rr_t1_no_issue", imem_en, 0);
    chk("rr_t1_valid", instr_valid, 0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("rr_issue_en", imem_en, 1);
    chk("rr_issue_addr", imem_addr, 8'h20);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("rr_gap_valid", instr_valid, 0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("rr_first_valid", instr_valid, 1);
    chk("rr_first_pc", instr_pc, 8'h20);
    drain("rr_drain", 10);

    // Reset mid-stream with the FIFO half full, then the stream restarts.
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("mid_half_occ", occupancy, 2);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("mid_rst_blocks_issue", imem_en, 0);
    stream_check(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
